// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch front end; owns the PC, reads imem over req/ack, hands words to decode over valid/ready, takes redirects, flags end of program.
//  Ports: clock/reset_n (async active-low); imem_req/imem_addr/imem_ack/imem_rdata (memory read);
//  ins_valid/ins_data/ins_pc/ins_ready (decode); redirect/redirect_pc (execute);
//  prog_words (program size in words); eof (end of program, sticky).
//  Macro FETCH_BOUND_CHECK_EN enables the program-bound check and eof.
module fetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] prog_words,
  output logic              eof
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, addr, addr_n, ipc_n, rpc;
  logic [DATA_W-1:0] data_n;
  logic drop, drop_n, enter, in_bound;
  assign rpc = redirect_pc & ~ADDR_W'(3);
  always_comb begin
    state_n = state;
    pc_n = pc;
    addr_n = addr;
    data_n = ins_data;
    ipc_n = ins_pc;
    drop_n = drop;
    enter = 1'b0;
    case (state)
      IDLE: begin
        enter = 1'b1;
        pc_n = redirect ? rpc : pc;
      end
      REQ: begin
        if (imem_ack && (redirect || drop)) begin
          // response belongs to a redirected-away path: discard and refetch
          enter = 1'b1;
          drop_n = 1'b0;
          pc_n = redirect ? rpc : pc;
        end else if (imem_ack) begin
          data_n = imem_rdata;
          ipc_n = addr;
          pc_n = pc + ADDR_W'(4);
          state_n = HOLD;
        end else if (redirect) begin
          // the outstanding read must complete before a new address can be issued
          drop_n = 1'b1;
          pc_n = rpc;
        end
      end
      HOLD: begin
        enter = redirect || ins_ready;
        pc_n = redirect ? rpc : pc;
      end
      default: begin
        enter = redirect;
        pc_n = redirect ? rpc : pc;
      end
    endcase
`ifdef FETCH_BOUND_CHECK_EN
    in_bound = {2'b00, pc_n} < {prog_words, 2'b00};
`else
    in_bound = 1'b1;
`endif
    if (enter) begin
      state_n = in_bound ? REQ : DONE;
      addr_n = pc_n;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      addr <= RESET_PC;
      ins_data <= '0;
      ins_pc <= RESET_PC;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      addr <= addr_n;
      ins_data <= data_n;
      ins_pc <= ipc_n;
      drop <= drop_n;
    end
  end
  assign imem_req = state == REQ;
  assign imem_addr = addr;
  assign ins_valid = state == HOLD;
`ifdef FETCH_BOUND_CHECK_EN
  assign eof = state == DONE;
`else
  logic unused_prog;
  assign unused_prog = ^prog_words;
  assign eof = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a transaction-level fetch model.
module tb_fetch_sequencer;
  logic clock = 1'b0, reset_n = 1'b0;
  logic imem_req, imem_ack = 1'b0, ins_valid, ins_ready = 1'b0, redirect = 1'b0, eof;
  logic [31:0] imem_addr, imem_rdata = '0, ins_data, ins_pc, redirect_pc = '0, prog_words = 32'd40;
  fetch_sequencer dut (
    .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ins_valid(ins_valid), .ins_data(ins_data),
    .ins_pc(ins_pc), .ins_ready(ins_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .prog_words(prog_words), .eof(eof)
  );
  always #5 clock = ~clock;
  int checks = 0, errors = 0, lat = 0, fixed_lat = -1, delivered = 0;
  logic [31:0] model_pc = '0, held = '0, last_pc = '0, sp, sd, s_data, s_pc;
  bit sv, sreq, sack;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit rdy, input bit rd, input logic [31:0] tgt);
    ins_ready = rdy;
    redirect = rd;
    redirect_pc = tgt;
    imem_ack = imem_req && lat == 0;
    imem_rdata = imem_ack ? memf(imem_addr) : $urandom;
    if (imem_req && lat > 0) lat--;
    sv = ins_valid; sp = ins_pc; sd = ins_data; sreq = imem_req; sack = imem_ack;
    @(posedge clock);
    if (sv && rdy) begin
      chk("ins_pc", sp, model_pc);
      chk("ins_data", sd, memf(model_pc));
      last_pc = sp;
      model_pc += 4;
      delivered++;
    end
    if (rd) model_pc = {tgt[31:2], 2'b00};
    @(negedge clock);
    ins_ready = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    if (imem_req && ins_valid) chk("req_in_hold", 1'b1, 1'b0);
    if (imem_req) begin
      if (!sreq || sack) begin
        chk("req_addr", imem_addr, model_pc);
`ifdef FETCH_BOUND_CHECK_EN
        chk("req_in_bound", {2'b00, model_pc} < {prog_words, 2'b00}, 1'b1);
`endif
        held = imem_addr;
        lat = fixed_lat < 0 ? int'($urandom_range(0, 3)) : fixed_lat;
      end else chk("addr_stable", imem_addr, held);
    end
`ifdef FETCH_BOUND_CHECK_EN
    if (eof) begin
      chk("eof_bound", {2'b00, model_pc} >= {prog_words, 2'b00}, 1'b1);
      chk("eof_quiet", {imem_req, ins_valid}, 2'b00);
    end
`else
    if (eof) chk("eof_off", eof, 1'b0);
`endif
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, ins_valid, 1'b0);
    chk({tag, "_data"}, ins_data, 32'h0);
    chk({tag, "_pc"}, ins_pc, 32'h0);
    chk({tag, "_eof"}, eof, 1'b0);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    ins_ready = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_vals("reset");
    reset_n = 1'b1;
    model_pc = '0;
    delivered = 0;
  endtask
  initial begin
    // 1: three-word program, ack one cycle after req, decode always ready
    prog_words = 32'd3;
    fixed_lat = 1;
    do_reset();
    for (int i = 0; i < 30 && !eof; i++) cyc(1'b1, 1'b0, '0);
`ifdef FETCH_BOUND_CHECK_EN
    chk("t1_eof", eof, 1'b1);
    chk("t1_count", delivered, 3);
    chk("t1_last", last_pc, 32'h8);
`else
    chk("t1_eof_off", eof, 1'b0);
    chk("t1_runs_on", delivered >= 3, 1'b1);
`endif
    // 2: decode stalls five cycles in HOLD
    prog_words = 32'd40;
    fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 10 && !ins_valid; i++) cyc(1'b0, 1'b0, '0);
    chk("t2_wait", ins_valid, 1'b1);
    s_data = ins_data;
    s_pc = ins_pc;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, '0);
      chk("t2_valid", ins_valid, 1'b1);
      chk("t2_data", ins_data, s_data);
      chk("t2_pc", ins_pc, s_pc);
      chk("t2_req", imem_req, 1'b0);
    end
    cyc(1'b1, 1'b0, '0);
    chk("t2_consumed", delivered, 1);
    // 3: redirect to 0x40 while the read of 4 is outstanding
    fixed_lat = 3;
    do_reset();
    for (int i = 0; i < 30 && !(imem_req && imem_addr == 32'h4); i++) cyc(1'b1, 1'b0, '0);
    chk("t3_wait", {imem_req, imem_addr}, {1'b1, 32'h4});
    cyc(1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 30 && delivered < 2; i++) cyc(1'b1, 1'b0, '0);
    chk("t3_count", delivered, 2);
    chk("t3_pc", last_pc, 32'h40);
    // 4: redirect to 0x80 in the same cycle decode accepts
    fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 10 && !ins_valid; i++) cyc(1'b0, 1'b0, '0);
    chk("t4_wait", ins_valid, 1'b1);
    cyc(1'b1, 1'b1, 32'h83);
    chk("t4_once", delivered, 1);
    for (int i = 0; i < 10 && delivered < 2; i++) cyc(1'b1, 1'b0, '0);
    chk("t4_pc", last_pc, 32'h80);
    // 5: reset during REQ, ack arrives while reset is held
    fixed_lat = 5;
    do_reset();
    for (int i = 0; i < 5 && !imem_req; i++) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("t5_in_req", imem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clock);
    @(negedge clock);
    imem_ack = 1'b0;
    check_reset_vals("t5_held");
    reset_n = 1'b1;
    model_pc = '0;
    delivered = 0;
    fixed_lat = 0;
    for (int i = 0; i < 5 && !imem_req; i++) cyc(1'b0, 1'b0, '0);
    chk("t5_restart", {imem_req, imem_addr}, {1'b1, 32'h0});
    // 6: empty program
    prog_words = 32'd0;
    do_reset();
    cyc(1'b1, 1'b0, '0);
`ifdef FETCH_BOUND_CHECK_EN
    chk("t6_eof", eof, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("t6_noreq", imem_req, 1'b0);
    end
    prog_words = 32'd4;
    cyc(1'b1, 1'b1, 32'h0);
    chk("t6_cleared", eof, 1'b0);
`else
    chk("t6_eof_off", eof, 1'b0);
`endif
    for (int i = 0; i < 10 && delivered < 1; i++) cyc(1'b1, 1'b0, '0);
    chk("t6_fetch0", {delivered == 1, last_pc}, {1'b1, 32'h0});
    // random traffic: latency, stalls and redirects all randomized
    prog_words = 32'd40;
    fixed_lat = -1;
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 200));
    chk("rand_progress", delivered > 100, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
